// File: rtl/risc_v_pipeline_pkg.sv
// Shared pipeline definitions: immediate format encodings and default widths.
package risc_v_pipeline_pkg;

   localparam int XLEN_DEFAULT  = 32;
   localparam int TAG_W_DEFAULT = 5;

   // Encoding 7 is deliberately left unnamed; it is the illegal select.
   typedef enum logic [2:0] {
      IMM_I  = 3'd0,
      IMM_S  = 3'd1,
      IMM_B  = 3'd2,
      IMM_J  = 3'd3,
      IMM_U  = 3'd4,
      IMM_Z  = 3'd5,
      IMM_SH = 3'd6
   } imm_sel_e;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Upstream/downstream handshake bundle for the immediate generator stage.
interface imm_gen_stage_if
   import risc_v_pipeline_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int TAG_W = TAG_W_DEFAULT
);
   logic             valid_i;
   logic             ready_o;
   logic [31:0]      inst_i;
   logic [2:0]       imm_sel_i;
   logic [TAG_W-1:0] tag_i;
   logic             flush_i;
   logic             valid_o;
   logic             ready_i;
   logic [XLEN-1:0]  imm_o;
   logic [TAG_W-1:0] tag_o;
   logic             err_o;

   modport master (
      output valid_i, inst_i, imm_sel_i, tag_i, flush_i, ready_i,
      input  ready_o, valid_o, imm_o, tag_o, err_o
   );

   modport slave (
      input  valid_i, inst_i, imm_sel_i, tag_i, flush_i, ready_i,
      output ready_o, valid_o, imm_o, tag_o, err_o
   );
endinterface

// File: rtl/imm_expand.sv
// Combinational immediate expansion of a raw instruction word into XLEN bits.
module imm_expand
   import risc_v_pipeline_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [31:0]     inst,
   input  logic [2:0]      sel,
   output logic [XLEN-1:0] imm,
   output logic            err
);

   // The opcode field never contributes to an immediate.
   logic unused_opcode;
   assign unused_opcode = ^inst[6:0];

   always_comb begin
      // NOTE: defaults assigned first so no case path can infer a latch.
      imm = '0;
      err = 1'b0;
      case (sel)
         IMM_I:  imm = XLEN'($signed(inst[31:20]));
         IMM_S:  imm = XLEN'($signed({inst[31:25], inst[11:7]}));
         IMM_B:  imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
         IMM_J:  imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
         IMM_U:  imm = XLEN'($signed({inst[31:12], 12'b0}));
         IMM_Z:  imm = XLEN'(inst[19:15]);
         IMM_SH: imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate generator stage: expansion at the input, then a 2-entry skid buffer
// (output register + skid register) with valid/ready on both sides.
module imm_gen_stage
   import risc_v_pipeline_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int TAG_W = TAG_W_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [31:0]      inst_i,
   input  logic [2:0]       imm_sel_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic             flush_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [XLEN-1:0]  imm_o,
   output logic [TAG_W-1:0] tag_o,
   output logic             err_o
);

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [TAG_W-1:0] tag;
      logic             err;
   } entry_t;

   logic [XLEN-1:0] exp_imm;
   logic            exp_err;
   entry_t          in_ent;
   entry_t          out_q;
   entry_t          skid_q;
   logic            out_valid_q;
   logic            skid_valid_q;
   logic            in_fire;
   logic            out_free;

   imm_expand #(.XLEN(XLEN)) u_expand (
      .inst (inst_i),
      .sel  (imm_sel_i),
      .imm  (exp_imm),
      .err  (exp_err)
   );

   assign in_ent   = '{imm: exp_imm, tag: tag_i, err: exp_err};
   assign ready_o  = ~skid_valid_q;
   assign in_fire  = valid_i & ready_o & ~flush_i;
   // The output slot can take new data when empty or being consumed this cycle.
   assign out_free = ~out_valid_q | ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!rst_ni) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_q        <= '0;
         skid_q       <= '0;
      end else if (flush_i) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else if (out_free) begin
         if (skid_valid_q) begin
            out_valid_q  <= 1'b1;
            out_q        <= skid_q;
            skid_valid_q <= 1'b0;
         end else begin
            out_valid_q <= in_fire;
            if (in_fire) out_q <= in_ent;
         end
      end else if (in_fire) begin
         skid_valid_q <= 1'b1;
         skid_q       <= in_ent;
      end
   end

   assign valid_o = out_valid_q;
   assign imm_o   = out_q.imm;
   assign tag_o   = out_q.tag;
   assign err_o   = out_q.err;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share stimulus and are
// compared every cycle against a 2-deep queue model of the skid buffer.
module tb_imm_gen_stage;
   import risc_v_pipeline_pkg::*;

   typedef struct {
      logic [63:0] imm64;
      logic [31:0] imm32;
      logic [4:0]  tag;
      logic        err;
   } ent_t;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   ent_t q[$];
   logic [4:0] seen[$];
   bit   last_acc;

   imm_gen_stage_if #(.XLEN(32), .TAG_W(5)) b32 ();
   imm_gen_stage_if #(.XLEN(64), .TAG_W(5)) b64 ();

   assign b64.valid_i   = b32.valid_i;
   assign b64.inst_i    = b32.inst_i;
   assign b64.imm_sel_i = b32.imm_sel_i;
   assign b64.tag_i     = b32.tag_i;
   assign b64.flush_i   = b32.flush_i;
   assign b64.ready_i   = b32.ready_i;

   imm_gen_stage #(.XLEN(32), .TAG_W(5)) dut32 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(b32.valid_i), .ready_o(b32.ready_o),
      .inst_i(b32.inst_i), .imm_sel_i(b32.imm_sel_i), .tag_i(b32.tag_i),
      .flush_i(b32.flush_i), .valid_o(b32.valid_o), .ready_i(b32.ready_i),
      .imm_o(b32.imm_o), .tag_o(b32.tag_o), .err_o(b32.err_o)
   );

   imm_gen_stage #(.XLEN(64), .TAG_W(5)) dut64 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(b64.valid_i), .ready_o(b64.ready_o),
      .inst_i(b64.inst_i), .imm_sel_i(b64.imm_sel_i), .tag_i(b64.tag_i),
      .flush_i(b64.flush_i), .valid_o(b64.valid_o), .ready_i(b64.ready_i),
      .imm_o(b64.imm_o), .tag_o(b64.tag_o), .err_o(b64.err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference immediate built from field arithmetic on a signed 32-bit word.
   function automatic logic [63:0] ref_imm(input logic [31:0] inst, input logic [2:0] sel, input bit x64);
      int s;
      int r;
      s = int'(inst);
      r = 0;
      case (sel)
         3'd0: r = s >>> 20;
         3'd1: r = ((s >>> 25) <<< 5) | int'(inst[11:7]);
         3'd2: r = ((s >>> 31) <<< 12) | (int'(inst[7]) << 11) | (int'(inst[30:25]) << 5) | (int'(inst[11:8]) << 1);
         3'd3: r = ((s >>> 31) <<< 20) | (int'(inst[19:12]) << 12) | (int'(inst[20]) << 11) | (int'(inst[30:21]) << 1);
         3'd4: r = s & 32'hFFFF_F000;
         3'd5: r = int'(inst[19:15]);
         3'd6: r = x64 ? int'(inst[25:20]) : int'(inst[24:20]);
         default: r = 0;
      endcase
      return 64'(longint'(r));
   endfunction

   function automatic ent_t mk(input logic [31:0] inst, input logic [2:0] sel, input logic [4:0] tg);
      ent_t e;
      logic [63:0] w32;
      w32     = ref_imm(inst, sel, 1'b0);
      e.imm64 = ref_imm(inst, sel, 1'b1);
      e.imm32 = w32[31:0];
      e.tag   = tg;
      e.err   = (sel == 3'd7);
      return e;
   endfunction

   task automatic compare_all();
      check("ready32", 64'(b32.ready_o), 64'(q.size() < 2));
      check("ready64", 64'(b64.ready_o), 64'(q.size() < 2));
      check("valid32", 64'(b32.valid_o), 64'(q.size() > 0));
      check("valid64", 64'(b64.valid_o), 64'(q.size() > 0));
      if (q.size() > 0) begin
         check("imm32", 64'(b32.imm_o), 64'(q[0].imm32));
         check("imm64", b64.imm_o, q[0].imm64);
         check("tag32", 64'(b32.tag_o), 64'(q[0].tag));
         check("tag64", 64'(b64.tag_o), 64'(q[0].tag));
         check("err32", 64'(b32.err_o), 64'(q[0].err));
         check("err64", 64'(b64.err_o), 64'(q[0].err));
      end
   endtask

   task automatic check_zero_outputs(input string name);
      check({name, "_valid32"}, 64'(b32.valid_o), 64'd0);
      check({name, "_ready32"}, 64'(b32.ready_o), 64'd1);
      check({name, "_imm32"},   64'(b32.imm_o),   64'd0);
      check({name, "_tag32"},   64'(b32.tag_o),   64'd0);
      check({name, "_err32"},   64'(b32.err_o),   64'd0);
      check({name, "_valid64"}, 64'(b64.valid_o), 64'd0);
      check({name, "_ready64"}, 64'(b64.ready_o), 64'd1);
      check({name, "_imm64"},   b64.imm_o,        64'd0);
   endtask

   // Called just after a falling edge: drive inputs, advance the model across
   // the next rising edge, then compare at the following falling edge.
   task automatic tick(input bit v, input logic [31:0] inst, input logic [2:0] sel,
                       input logic [4:0] tg, input bit rdy, input bit fl);
      bit acc;
      b32.valid_i   = v;
      b32.inst_i    = inst;
      b32.imm_sel_i = sel;
      b32.tag_i     = tg;
      b32.ready_i   = rdy;
      b32.flush_i   = fl;
      if (b32.valid_o && rdy && !fl) seen.push_back(b32.tag_o);
      acc = v && !fl && (q.size() < 2);
      if (fl) q.delete();
      else begin
         if (q.size() > 0 && rdy) void'(q.pop_front());
         if (acc) q.push_back(mk(inst, sel, tg));
      end
      last_acc = acc;
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input bit rdy);
      tick(1'b0, 32'h0, 3'd0, 5'd0, rdy, 1'b0);
   endtask

   initial begin
      int idx;
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      b32.valid_i = 1'b0; b32.inst_i = '0; b32.imm_sel_i = '0;
      b32.tag_i = '0; b32.ready_i = 1'b0; b32.flush_i = 1'b0;

      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst_n = 1'b1;
      compare_all();

      // Directed immediates, back-to-back with ready_i=1.
      tick(1'b1, 32'hFFF0_0093, IMM_I, 5'd1, 1'b1, 1'b0);
      check("dir_i_imm32", 64'(b32.imm_o), 64'hFFFF_FFFF);
      check("dir_i_err32", 64'(b32.err_o), 64'd0);
      tick(1'b1, 32'hFE00_0EE3, IMM_B, 5'd2, 1'b1, 1'b0);
      check("dir_b_imm32", 64'(b32.imm_o), 64'hFFFF_FFFC);
      tick(1'b1, 32'h1234_50B7, IMM_U, 5'd3, 1'b1, 1'b0);
      check("dir_u_imm32", 64'(b32.imm_o), 64'h1234_5000);
      tick(1'b1, 32'h8000_00B7, IMM_U, 5'd4, 1'b1, 1'b0);
      check("dir_u_imm64", b64.imm_o, 64'hFFFF_FFFF_8000_0000);
      tick(1'b1, 32'h03F0_D093, IMM_SH, 5'd5, 1'b1, 1'b0);
      check("dir_sh_imm64", b64.imm_o, 64'h3F);
      check("dir_sh_imm32", 64'(b32.imm_o), 64'h1F);
      tick(1'b1, 32'h000F_8073, IMM_Z, 5'd6, 1'b1, 1'b0);
      check("dir_z_imm64", b64.imm_o, 64'h1F);
      tick(1'b1, 32'hFFFF_FFFF, 3'd7, 5'd7, 1'b1, 1'b0);
      check("dir_ill_imm32", 64'(b32.imm_o), 64'd0);
      check("dir_ill_err32", 64'(b32.err_o), 64'd1);
      check("dir_ill_imm64", b64.imm_o, 64'd0);
      tick(1'b1, 32'h0050_0093, IMM_I, 5'd8, 1'b1, 1'b0);
      check("dir_after_ill_err", 64'(b32.err_o), 64'd0);
      idle(1'b1);

      // Back-pressure: ready_i low for 3 cycles while 4 tagged entries stream in.
      seen.delete();
      tick(1'b1, 32'h0010_0093, IMM_I, 5'd1, 1'b0, 1'b0);
      tick(1'b1, 32'h0020_0093, IMM_I, 5'd2, 1'b0, 1'b0);
      check("bp_ready_drop", 64'(b32.ready_o), 64'd0);
      tick(1'b1, 32'h0030_0093, IMM_I, 5'd3, 1'b0, 1'b0);
      check("bp_hold_tag", 64'(b32.tag_o), 64'd1);
      check("bp_hold_imm", 64'(b32.imm_o), 64'd1);
      idx = 3;
      for (int c = 0; c < 12 && (idx <= 4 || q.size() > 0); c++) begin
         tick(idx <= 4, 32'(idx) << 20, IMM_I, 5'(idx), 1'b1, 1'b0);
         if (last_acc) idx++;
      end
      check("bp_seen_count", 64'(seen.size()), 64'd4);
      for (int i = 0; i < 4 && i < seen.size(); i++)
         check("bp_order", 64'(seen[i]), 64'(i + 1));

      // Flush with two entries held, input presented in the same cycle.
      tick(1'b1, 32'h0AA0_0093, IMM_I, 5'd10, 1'b0, 1'b0);
      tick(1'b1, 32'h0BB0_0093, IMM_I, 5'd11, 1'b0, 1'b0);
      tick(1'b1, 32'h0CC0_0093, IMM_I, 5'd9, 1'b0, 1'b1);
      check("flush_valid", 64'(b32.valid_o), 64'd0);
      check("flush_ready", 64'(b32.ready_o), 64'd1);
      idle(1'b1);
      check("flush_discard", 64'(b32.valid_o), 64'd0);

      // Asynchronous reset mid-stream.
      tick(1'b1, 32'hFFF0_0093, IMM_S, 5'd12, 1'b0, 1'b0);
      tick(1'b1, 32'hFFF0_0093, IMM_J, 5'd13, 1'b0, 1'b0);
      b32.valid_i = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_zero_outputs("async_rst");
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      compare_all();

      // Randomized traffic.
      for (int i = 0; i < 400; i++)
         tick($urandom_range(0, 9) < 7, $urandom, 3'($urandom_range(0, 7)),
              5'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3);
      idle(1'b1);
      idle(1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
